// File: rtl/act_mem_arbiter.sv
// Activation RAM arbiter: video reads have fixed priority, the accelerator uses free slots.
// Optional ACT_ARB_WRPROTECT_EN stalls accel writes to the address video read last cycle.
module act_mem_arbiter #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 12288,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_rvalid,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              acc_err,
  output logic              acc_starve,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);
  localparam logic [CntW-1:0] LimitW = CntW'(STARVE_LIMIT);

  typedef enum logic [2:0] {TagNone, TagVid, TagAccRd, TagAccWr, TagErr} tag_e;

  tag_e              tag_d, tag_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] vid_rdata_q, acc_rdata_q;
  logic [CntW-1:0]   cnt_d, cnt_q;
  logic              starve_q;
  logic              acc_in_range;
  logic              hazard;

  assign acc_in_range = {1'b0, acc_addr} < DepthW;

`ifdef ACT_ARB_WRPROTECT_EN
  logic              prev_vid_req_q;
  logic [ADDR_W-1:0] prev_vid_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vid_req_q  <= 1'b0;
      prev_vid_addr_q <= '0;
    end else begin
      prev_vid_req_q  <= vid_req;
      prev_vid_addr_q <= vid_addr;
    end
  end

  // Keeps a write from landing mid-way through the pixel triplet video is fetching.
  assign hazard = acc_valid & acc_we & prev_vid_req_q & (acc_addr == prev_vid_addr_q);
`else
  assign hazard = 1'b0;
`endif

  // Grant: address/data hold their last driven values whenever the RAM is not accessed.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    acc_ready = 1'b0;
    tag_d     = TagNone;
    if (vid_req) begin
      mem_en   = 1'b1;
      mem_addr = vid_addr;
      tag_d    = TagVid;
    end else if (acc_valid && !hazard) begin
      acc_ready = 1'b1;
      if (acc_in_range) begin
        mem_en    = 1'b1;
        mem_we    = acc_we;
        mem_addr  = acc_addr;
        mem_wdata = acc_wdata;
        tag_d     = acc_we ? TagAccWr : TagAccRd;
      end else begin
        tag_d = TagErr;
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    if (acc_valid && !acc_ready) begin
      cnt_d = (cnt_q >= LimitW) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_comb begin
    vid_rvalid = (tag_q == TagVid);
    vid_rdata  = vid_rvalid ? mem_rdata : vid_rdata_q;
    acc_rvalid = (tag_q == TagAccRd) || (tag_q == TagAccWr) || (tag_q == TagErr);
    acc_err    = (tag_q == TagErr);
    acc_rdata  = acc_rdata_q;
    if (tag_q == TagAccRd) begin
      acc_rdata = mem_rdata;
    end else if (tag_q == TagErr) begin
      acc_rdata = '0;
    end
  end

  assign acc_starve = starve_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= TagNone;
      addr_q      <= '0;
      wdata_q     <= '0;
      vid_rdata_q <= '0;
      acc_rdata_q <= '0;
      cnt_q       <= '0;
      starve_q    <= 1'b0;
    end else begin
      tag_q       <= tag_d;
      addr_q      <= mem_addr;
      wdata_q     <= mem_wdata;
      vid_rdata_q <= vid_rdata;
      acc_rdata_q <= acc_rdata;
      cnt_q       <= cnt_d;
      starve_q    <= (cnt_d >= LimitW);
    end
  end

endmodule

// File: tb/tb_act_mem_arbiter.sv
// Randomized bench for act_mem_arbiter: bench-side RAM plus a transaction-level reference model.
module tb_act_mem_arbiter;
  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int DEPTH = 12288;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_rdata;
  logic          vid_rvalid;
  logic          acc_valid = 1'b0;
  logic          acc_ready;
  logic          acc_we = 1'b0;
  logic [AW-1:0] acc_addr = '0;
  logic [DW-1:0] acc_wdata = '0;
  logic          acc_rvalid;
  logic [DW-1:0] acc_rdata;
  logic          acc_err;
  logic          acc_starve;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  act_mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_rdata  (vid_rdata),
    .vid_rvalid (vid_rvalid),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_we     (acc_we),
    .acc_addr   (acc_addr),
    .acc_wdata  (acc_wdata),
    .acc_rvalid (acc_rvalid),
    .acc_rdata  (acc_rdata),
    .acc_err    (acc_err),
    .acc_starve (acc_starve),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Physical RAM driven by the DUT, and the model's own view of what RAM must hold.
  logic [DW-1:0] ram    [0:16383];
  logic [DW-1:0] shadow [0:16383];

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: kind of response owed next cycle (0 none, 1 video, 2 acc read, 3 acc write, 4 error)
  int            exp_resp = 0;
  logic [DW-1:0] pend_data = '0;
  logic [DW-1:0] exp_vdata = '0;
  logic [DW-1:0] exp_adata = '0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;
  int            denied = 0;
  int            ready_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input logic vr, input logic [AW-1:0] va, input logic av, input logic aw,
                      input logic [AW-1:0] aa, input logic [DW-1:0] ad, input bit do_rst);
    int            g;
    logic          c_en, c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    rst_n     = 1'b1;
    vid_req   = vr;
    vid_addr  = va;
    acc_valid = av;
    acc_we    = aw;
    acc_addr  = aa;
    acc_wdata = ad;
    #3;
    check("vid_rvalid", vid_rvalid, exp_resp == 1);
    check("acc_rvalid", acc_rvalid, exp_resp >= 2);
    check("acc_err", acc_err, exp_resp == 4);
    if (exp_resp == 1) exp_vdata = pend_data;
    if (exp_resp == 2) exp_adata = pend_data;
    if (exp_resp == 4) exp_adata = '0;
    check("vid_rdata", vid_rdata, exp_vdata);
    check("acc_rdata", acc_rdata, exp_adata);
    check("acc_starve", acc_starve, denied >= LIMIT);

    if (vr) g = 1;
    else if (av && int'(aa) < DEPTH) g = 2;
    else if (av) g = 3;
    else g = 0;
    check("acc_ready", acc_ready, g >= 2);
    check("mem_en", mem_en, g == 1 || g == 2);
    check("mem_we", mem_we, g == 2 && aw);
    if (g == 1) check("mem_addr_vid", mem_addr, va);
    if (g == 2) begin
      check("mem_addr_acc", mem_addr, aa);
      check("mem_wdata", mem_wdata, ad);
    end
    if (g == 0) begin
      check("mem_addr_hold", mem_addr, last_addr);
      check("mem_wdata_hold", mem_wdata, last_wdata);
    end
    if (acc_ready) ready_seen++;

    if (av && g < 2) denied = (denied < LIMIT) ? denied + 1 : denied;
    else denied = 0;
    case (g)
      1: begin
        exp_resp  = 1;
        pend_data = shadow[va];
        last_addr = va;
      end
      2: begin
        last_addr  = aa;
        last_wdata = ad;
        if (aw) begin
          shadow[aa] = ad;
          exp_resp   = 3;
        end else begin
          exp_resp  = 2;
          pend_data = shadow[aa];
        end
      end
      3: exp_resp = 4;
      default: exp_resp = 0;
    endcase

    c_en    = mem_en;
    c_we    = mem_we;
    c_addr  = mem_addr;
    c_wdata = mem_wdata;
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      check("rst_vid_rvalid", vid_rvalid, 0);
      check("rst_acc_rvalid", acc_rvalid, 0);
      check("rst_acc_err", acc_err, 0);
      check("rst_acc_starve", acc_starve, 0);
      exp_resp   = 0;
      exp_vdata  = '0;
      exp_adata  = '0;
      last_addr  = '0;
      last_wdata = '0;
      denied     = 0;
    end
    @(posedge clk);
    #1;
    if (c_en) begin
      if (c_we) ram[c_addr] = c_wdata;
      else mem_rdata = ram[c_addr];
    end
  endtask

  logic          hv, hw, vr;
  logic [AW-1:0] ha;
  logic [DW-1:0] hd;

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ram[i]    = 8'($urandom);
      shadow[i] = ram[i];
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_vid_rvalid", vid_rvalid, 0);
    check("reset_acc_rdata", acc_rdata, 0);

    // Reset release, no requests
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Video priority over a pending accel read
    step(1, 14'h0020, 1, 0, 14'h0010, 0, 0);
    step(0, 0, 1, 0, 14'h0010, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Write then read back
    step(0, 0, 1, 1, 14'h0100, 8'hA5, 0);
    step(0, 0, 1, 0, 14'h0100, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("lit_readback", acc_rdata, 8'hA5);
    check("lit_readback_err", acc_err, 0);

    // Out of range
    step(0, 0, 1, 0, 14'(DEPTH), 0, 0);
    check("lit_oor_rvalid", acc_rvalid, 1);
    check("lit_oor_err", acc_err, 1);
    check("lit_oor_rdata", acc_rdata, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Starvation
    for (int i = 1; i <= 10; i++) begin
      step(1, 14'(i), 1, 0, 14'h0040, 0, 0);
      if (i == 7) check("lit_starve_7", acc_starve, 0);
      if (i == 8) check("lit_starve_8", acc_starve, 1);
    end
    step(0, 0, 1, 0, 14'h0040, 0, 0);
    check("lit_starve_clear", acc_starve, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Video on 3 of every 4 cycles, continuous accel reads
    ready_seen = 0;
    ha = 14'($urandom_range(0, DEPTH - 1));
    for (int i = 0; i < 64; i++) begin
      vr = (i % 4) != 3;
      step(vr, 14'($urandom_range(0, DEPTH - 1)), 1, 0, ha, 0, 0);
      if (!vr) ha = 14'($urandom_range(0, DEPTH - 1));
    end
    check("lit_cadence_grants", ready_seen, 16);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-stream with a video response in flight and an accel write granted
    step(1, 14'h0300, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 14'h0200, 8'h3C, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 14'h0200, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("lit_rst_write_kept", acc_rdata, 8'h3C);

    // Random traffic with held accel requests
    hv = 1'b0; hw = 1'b0; ha = '0; hd = '0;
    for (int i = 0; i < 3000; i++) begin
      vr = ($urandom_range(0, 2) == 0);
      if (!hv) begin
        hv = ($urandom_range(0, 3) != 0);
        hw = $urandom_range(0, 1) == 1;
        ha = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(DEPTH, 16383))
                                         : 14'($urandom_range(0, 63));
        hd = 8'($urandom);
      end
      step(vr, 14'($urandom_range(0, 63)), hv, hw, ha, hd, (i % 700) == 699);
      if (hv && !vr) hv = 1'b0;
    end
    step(0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
